// File: rtl/fifo_fwft_flags.sv
// First-word-fall-through FIFO with occupancy flags, flush and optional sticky errors.
// Define FIFO_FWFT_FLAGS_ERR_EN to build the overflow/underflow registers.
module fifo_fwft_flags #(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned ADDR_WIDTH   = 4,
  parameter int unsigned AFULL_LEVEL  = (1 << ADDR_WIDTH) - 2,
  parameter int unsigned AEMPTY_LEVEL = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  enQ,
  input  logic                  deQ,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_empty,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   count,
  input  logic                  clear_err,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam int unsigned CW    = ADDR_WIDTH + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] enq_ptr_q, enq_ptr_d;
  logic [ADDR_WIDTH-1:0] deq_ptr_q, deq_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  wr, rd, bypass, mem_we;

  assign empty        = (count_q == '0);
  assign full         = (count_q == CW'(DEPTH));
  assign almost_empty = (count_q <= CW'(AEMPTY_LEVEL));
  assign almost_full  = (count_q >= CW'(AFULL_LEVEL));
  assign count        = count_q;

  assign wr     = enQ & (~full | deQ);
  assign rd     = deQ & (~empty | enQ);
  assign bypass = wr & rd & empty;
  assign mem_we = ~flush & wr & ~bypass;

  // Empty FIFO with a pending enqueue presents the incoming word directly.
  assign data_out = (empty & enQ) ? data_in : mem[deq_ptr_q];

  always_comb begin
    enq_ptr_d = enq_ptr_q;
    deq_ptr_d = deq_ptr_q;
    count_d   = count_q;
    if (flush) begin
      enq_ptr_d = '0;
      deq_ptr_d = '0;
      count_d   = '0;
    end else if (bypass) begin
      count_d = count_q;
    end else if (wr && rd) begin
      enq_ptr_d = enq_ptr_q + ADDR_WIDTH'(1);
      deq_ptr_d = deq_ptr_q + ADDR_WIDTH'(1);
    end else if (wr) begin
      enq_ptr_d = enq_ptr_q + ADDR_WIDTH'(1);
      count_d   = count_q + CW'(1);
    end else if (rd) begin
      deq_ptr_d = deq_ptr_q + ADDR_WIDTH'(1);
      count_d   = count_q - CW'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      enq_ptr_q <= '0;
      deq_ptr_q <= '0;
      count_q   <= '0;
    end else begin
      enq_ptr_q <= enq_ptr_d;
      deq_ptr_q <= deq_ptr_d;
      count_q   <= count_d;
    end
  end

  // Storage is intentionally not reset.
  always_ff @(posedge clock) begin
    if (mem_we) mem[enq_ptr_q] <= data_in;
  end

`ifdef FIFO_FWFT_FLAGS_ERR_EN
  logic ovf_q, ovf_d, unf_q, unf_d;
  logic ovf_set, unf_set;

  assign ovf_set = enQ & full & ~deQ & ~flush;
  assign unf_set = deQ & empty & ~enQ & ~flush;

  // A new error in the same cycle as clear_err survives the clear.
  always_comb begin
    ovf_d = ovf_set | (ovf_q & ~clear_err);
    unf_d = unf_set | (unf_q & ~clear_err);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign overflow  = ovf_q;
  assign underflow = unf_q;
`else
  logic unused_clear_err;
  assign unused_clear_err = clear_err;
  assign overflow         = 1'b0;
  assign underflow        = 1'b0;
`endif

endmodule
